pop_pair_streamer: RTL and testbench
====================================

Name: pop_pair_streamer

Overview:
- Producer side of the best-fitness tracker interface.
- Per generation: clears the tracker, walks population memory two chromosomes per cycle, routes each pair through the fitness evaluators, and presents aligned (fitness, chrom) pairs plus enable_second.
- Handles odd population sizes and evaluator pipeline latency.
- Signals generation completion to the GA controller.

Parameters:
- CHROM_WIDTH, 8, chromosome bit width
- FIT_WIDTH, 27, fitness bit width; lower fitness is better
- POP_SIZE, 10, chromosomes per generation; range 1..2**ADDR_WIDTH
- ADDR_WIDTH, 4, population memory address width
- FIT_LATENCY, 2, evaluator cycles from eval_chrom to eval_fit; must be >= 1

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a generation scan
- mem_addr1  out  ADDR_WIDTH  read address, even slot
- mem_addr2  out  ADDR_WIDTH  read address, odd slot
- mem_rd_en  out  1  read strobe; read data is valid the next cycle
- mem_rdata1  in  CHROM_WIDTH  data for mem_addr1
- mem_rdata2  in  CHROM_WIDTH  data for mem_addr2
- eval_chrom1  out  CHROM_WIDTH  evaluator 1 input (mem_rdata1 passed through)
- eval_chrom2  out  CHROM_WIDTH  evaluator 2 input (mem_rdata2 passed through)
- eval_fit1  in  FIT_WIDTH  evaluator 1 result, FIT_LATENCY cycles after eval_chrom1
- eval_fit2  in  FIT_WIDTH  evaluator 2 result
- best_clear  out  1  tracker clear pulse, wired to the tracker's reset
- fitness1  out  FIT_WIDTH  pair fitness, slot 1
- fitness2  out  FIT_WIDTH  pair fitness, slot 2
- chrom1  out  CHROM_WIDTH  chromosome aligned with fitness1
- chrom2  out  CHROM_WIDTH  chromosome aligned with fitness2
- enable_second  out  1  slot 2 holds a valid entry
- pair_valid  out  1  slot 1 holds a valid entry
- busy  out  1  generation in progress
- done  out  1  one-cycle pulse when the last pair has been presented

Behaviour:
- Reset (asynchronous): state IDLE. All outputs 0 except fitness1 and fitness2, which are all ones. All pipeline valid bits cleared. Reset mid-scan aborts the scan with no done pulse.
- Idle output rule: whenever pair_valid=0, drive fitness1 and fitness2 to all ones, enable_second=0, and chrom outputs to 0. This guarantees the tracker never updates on a bubble.
- FSM:
  - IDLE: wait for start. start while busy is ignored.
  - CLEAR: best_clear=1 for exactly one cycle; go to ISSUE. busy=1 from this cycle until done.
  - ISSUE: one pair per cycle. mem_rd_en=1, mem_addr1=2k, mem_addr2=2k+1, k=0..ceil(POP_SIZE/2)-1.
  - ISSUE, last pair: if POP_SIZE is odd, mem_addr2 is driven 0 and the pair's second-valid flag is 0. After the last pair, go to DRAIN.
  - DRAIN: wait until all in-flight valid bits have retired.
  - DONE: done=1 and busy=0 for one cycle; return to IDLE.
- Addresses and mem_rd_en are registered outputs, visible in the cycle they are issued.
- Latency: a pair issued in cycle t appears on the registered outputs in cycle t+2+FIT_LATENCY.
  - Read data returns at t+1 and passes combinationally to eval_chrom.
  - eval_fit is sampled at t+1+FIT_LATENCY.
- Alignment: chromosomes travel through a FIT_LATENCY-deep delay line alongside the {valid, second_valid} bit pair, then into the output register together with eval_fit.
- Output contract: pair_valid=1 for ceil(POP_SIZE/2) consecutive cycles. enable_second follows second_valid.
- done fires in the cycle after the last pair_valid.
- start in the DONE cycle is ignored; it is accepted the next cycle in IDLE.
- Tracker handshake: best_clear precedes the first pair_valid by at least 3+FIT_LATENCY cycles. The tracker's best output is final in the cycle done is high.

Decomposition:
- Shared package ga_pkg holds:
  - FIT_WIDTH and CHROM_WIDTH defaults
  - fit_t and chrom_t typedefs
  - FIT_WORST, the all-ones constant
  - the scan-state enum
- One sub-module, fit_align_pipe: a parameterised delay line (depth FIT_LATENCY) for the chromosome pair plus valid bits.

Test Plan:
- Even population: POP_SIZE=10, FIT_LATENCY=2, start at cycle 0.
  - best_clear at cycle 1.
  - Addresses 0/1..8/9 in cycles 2..6.
  - pair_valid in cycles 6..10, all with enable_second=1.
  - done at cycle 11.
- Odd population: POP_SIZE=5.
  - 3 issue cycles; last pair has enable_second=0 and fitness2=all ones.
  - A connected tracker reports the minimum of 5 programmed fitness values, including when the minimum sits in slot 4.
- Idle bubbles: between generations, fitness1=all ones and pair_valid=0.
  - Tracker best_fit stays unchanged across 20 idle cycles.
- Reset mid-scan: assert reset in the 3rd ISSUE cycle.
  - All outputs return to reset values immediately, with no done pulse.
  - A new start completes a full normal scan.
- start during busy: pulse start in CLEAR and in DRAIN.
  - Ignored: exactly one done pulse, and pair count unchanged.
- Latency sweep: FIT_LATENCY=1 and 4, POP_SIZE=1.
  - A single pair appears at issue+3 and issue+6 respectively, with enable_second=0.
  - done follows one cycle later.

Source files
------------

// File: rtl/ga_pkg.sv
// Shared GA datapath types: default widths, fitness/chromosome types, scan states.
// Pure declarations; no latency and no flow control.
package ga_pkg;

   localparam int CHROM_WIDTH = 8;
   localparam int FIT_WIDTH   = 27;

   typedef logic [CHROM_WIDTH-1:0] chrom_t;
   typedef logic [FIT_WIDTH-1:0]   fit_t;

   // Lower fitness is better, so all ones can never win a comparison.
   localparam fit_t FIT_WORST = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } scan_state_t;

endpackage

// File: rtl/fit_align_pipe.sv
// Fixed-depth delay line that carries a chromosome pair and its valid bits.
// Latency DEPTH cycles; no backpressure, one entry accepted every cycle.
module fit_align_pipe #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pair_vld,
   input  logic [WIDTH-1:0] pair_dat,
   output logic             aligned_vld,
   output logic [WIDTH-1:0] aligned_dat,
   output logic             any_vld
);

   logic [DEPTH-1:0] vld_q;
   logic [WIDTH-1:0] dat_q [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
         for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
      end else begin
         vld_q[0] <= pair_vld;
         dat_q[0] <= pair_dat;
         for (int i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign aligned_vld = vld_q[DEPTH-1];
   assign aligned_dat = dat_q[DEPTH-1];
   assign any_vld     = |vld_q;

endmodule

// File: rtl/pop_pair_streamer.sv
// Per generation: clear tracker, stream population pairs through the evaluators, present aligned results.
// Latency issue->output 2+FIT_LATENCY cycles; no backpressure, the tracker must accept one pair per cycle.
module pop_pair_streamer #(
   parameter int CHROM_WIDTH = ga_pkg::CHROM_WIDTH,
   parameter int FIT_WIDTH   = ga_pkg::FIT_WIDTH,
   parameter int POP_SIZE    = 10,
   parameter int ADDR_WIDTH  = 4,
   parameter int FIT_LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   output logic [ADDR_WIDTH-1:0]  mem_addr1,
   output logic [ADDR_WIDTH-1:0]  mem_addr2,
   output logic                   mem_rd_en,
   input  logic [CHROM_WIDTH-1:0] mem_rdata1,
   input  logic [CHROM_WIDTH-1:0] mem_rdata2,
   output logic [CHROM_WIDTH-1:0] eval_chrom1,
   output logic [CHROM_WIDTH-1:0] eval_chrom2,
   input  logic [FIT_WIDTH-1:0]   eval_fit1,
   input  logic [FIT_WIDTH-1:0]   eval_fit2,
   output logic                   best_clear,
   output logic [FIT_WIDTH-1:0]   fitness1,
   output logic [FIT_WIDTH-1:0]   fitness2,
   output logic [CHROM_WIDTH-1:0] chrom1,
   output logic [CHROM_WIDTH-1:0] chrom2,
   output logic                   enable_second,
   output logic                   pair_valid,
   output logic                   busy,
   output logic                   done
);

   import ga_pkg::*;

   localparam int                    NUM_PAIRS = (POP_SIZE + 1) / 2;
   localparam logic [ADDR_WIDTH-1:0] LAST_PAIR = ADDR_WIDTH'(NUM_PAIRS - 1);
   localparam int                    PAIR_W    = 1 + 2 * CHROM_WIDTH;
   localparam logic [FIT_WIDTH-1:0]  FIT_NONE  = '1;

   scan_state_t             state;
   logic [ADDR_WIDTH-1:0]   pair_idx;
   logic [ADDR_WIDTH-1:0]   next_idx;
   logic [ADDR_WIDTH:0]     even_slot;
   logic                    odd_slot_ok;
   logic                    issue_sec;
   logic                    rd_vld;
   logic                    rd_sec;
   logic                    aligned_vld;
   logic                    pipe_busy;
   logic [PAIR_W-1:0]       aligned_dat;
   logic                    aligned_sec;
   logic [CHROM_WIDTH-1:0]  aligned_c1;
   logic [CHROM_WIDTH-1:0]  aligned_c2;

   always_comb begin
      next_idx    = (state == S_CLEAR) ? '0 : pair_idx + ADDR_WIDTH'(1);
      even_slot   = {next_idx, 1'b0};
      odd_slot_ok = (int'(even_slot) + 1) < POP_SIZE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         pair_idx   <= '0;
         best_clear <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         mem_rd_en  <= 1'b0;
         mem_addr1  <= '0;
         mem_addr2  <= '0;
         issue_sec  <= 1'b0;
      end else begin
         best_clear <= 1'b0;
         done       <= 1'b0;
         mem_rd_en  <= 1'b0;
         mem_addr1  <= '0;
         mem_addr2  <= '0;
         issue_sec  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_CLEAR;
                  best_clear <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            // The CLEAR cycle already computes pair 0 so issue starts back-to-back.
            S_CLEAR, S_ISSUE: begin
               if (state == S_ISSUE && pair_idx == LAST_PAIR) begin
                  state <= S_DRAIN;
               end else begin
                  state     <= S_ISSUE;
                  pair_idx  <= next_idx;
                  mem_rd_en <= 1'b1;
                  mem_addr1 <= even_slot[ADDR_WIDTH-1:0];
                  if (odd_slot_ok) begin
                     mem_addr2 <= even_slot[ADDR_WIDTH-1:0] | ADDR_WIDTH'(1);
                     issue_sec <= 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (!rd_vld && !pipe_busy) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_vld <= 1'b0;
         rd_sec <= 1'b0;
      end else begin
         rd_vld <= mem_rd_en;
         rd_sec <= issue_sec;
      end
   end

   assign eval_chrom1 = mem_rdata1;
   assign eval_chrom2 = mem_rdata2;

   fit_align_pipe #(
      .DEPTH (FIT_LATENCY),
      .WIDTH (PAIR_W)
   ) u_align (
      .clk         (clk),
      .reset       (reset),
      .pair_vld    (rd_vld),
      .pair_dat    ({rd_sec, mem_rdata1, mem_rdata2}),
      .aligned_vld (aligned_vld),
      .aligned_dat (aligned_dat),
      .any_vld     (pipe_busy)
   );

   assign {aligned_sec, aligned_c1, aligned_c2} = aligned_dat;

   // Bubbles carry worst fitness so the tracker can never latch them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pair_valid    <= 1'b0;
         enable_second <= 1'b0;
         fitness1      <= FIT_NONE;
         fitness2      <= FIT_NONE;
         chrom1        <= '0;
         chrom2        <= '0;
      end else if (aligned_vld) begin
         pair_valid    <= 1'b1;
         fitness1      <= eval_fit1;
         chrom1        <= aligned_c1;
         enable_second <= aligned_sec;
         fitness2      <= aligned_sec ? eval_fit2 : FIT_NONE;
         chrom2        <= aligned_sec ? aligned_c2 : '0;
      end else begin
         pair_valid    <= 1'b0;
         enable_second <= 1'b0;
         fitness1      <= FIT_NONE;
         fitness2      <= FIT_NONE;
         chrom1        <= '0;
         chrom2        <= '0;
      end
   end

endmodule

// File: tb/tb_pop_pair_streamer.sv
// Four streamers (POP 10/L2, POP 5/L2, POP 1/L1, POP 1/L4) with memory, evaluator and tracker models.
// Expected timing and values are derived per cycle from the scan schedule and population contents.
module tb_pop_pair_streamer;

   localparam int POPS [4] = '{10, 5, 1, 1};
   localparam int LATS [4] = '{2, 2, 1, 4};
   localparam logic [26:0] ALL1 = '1;

   logic        clk = 1'b0;
   logic        reset;
   logic        start [4];
   logic [3:0]  addr1 [4];
   logic [3:0]  addr2 [4];
   logic        rd_en [4];
   logic [7:0]  rdata1 [4];
   logic [7:0]  rdata2 [4];
   logic [7:0]  ec1 [4];
   logic [7:0]  ec2 [4];
   logic [26:0] ef1 [4];
   logic [26:0] ef2 [4];
   logic        clr [4];
   logic [26:0] f1 [4];
   logic [26:0] f2 [4];
   logic [7:0]  c1 [4];
   logic [7:0]  c2 [4];
   logic        en2 [4];
   logic        pv [4];
   logic        busy [4];
   logic        done [4];

   logic [7:0]  mem [4][16];
   logic [26:0] fit_tab [256];
   logic [26:0] ev1 [4][4];
   logic [26:0] ev2 [4][4];
   logic [26:0] best [4];
   logic [26:0] cand;

   int checks = 0;
   int errors = 0;
   int cur_n  = 0;

   always #5 clk = ~clk;

   pop_pair_streamer #(.CHROM_WIDTH(8), .FIT_WIDTH(27), .POP_SIZE(10), .ADDR_WIDTH(4), .FIT_LATENCY(2)) u_dut0 (
      .clk(clk), .reset(reset), .start(start[0]), .mem_addr1(addr1[0]), .mem_addr2(addr2[0]), .mem_rd_en(rd_en[0]),
      .mem_rdata1(rdata1[0]), .mem_rdata2(rdata2[0]), .eval_chrom1(ec1[0]), .eval_chrom2(ec2[0]),
      .eval_fit1(ef1[0]), .eval_fit2(ef2[0]), .best_clear(clr[0]), .fitness1(f1[0]), .fitness2(f2[0]),
      .chrom1(c1[0]), .chrom2(c2[0]), .enable_second(en2[0]), .pair_valid(pv[0]), .busy(busy[0]), .done(done[0]));

   pop_pair_streamer #(.CHROM_WIDTH(8), .FIT_WIDTH(27), .POP_SIZE(5), .ADDR_WIDTH(4), .FIT_LATENCY(2)) u_dut1 (
      .clk(clk), .reset(reset), .start(start[1]), .mem_addr1(addr1[1]), .mem_addr2(addr2[1]), .mem_rd_en(rd_en[1]),
      .mem_rdata1(rdata1[1]), .mem_rdata2(rdata2[1]), .eval_chrom1(ec1[1]), .eval_chrom2(ec2[1]),
      .eval_fit1(ef1[1]), .eval_fit2(ef2[1]), .best_clear(clr[1]), .fitness1(f1[1]), .fitness2(f2[1]),
      .chrom1(c1[1]), .chrom2(c2[1]), .enable_second(en2[1]), .pair_valid(pv[1]), .busy(busy[1]), .done(done[1]));

   pop_pair_streamer #(.CHROM_WIDTH(8), .FIT_WIDTH(27), .POP_SIZE(1), .ADDR_WIDTH(4), .FIT_LATENCY(1)) u_dut2 (
      .clk(clk), .reset(reset), .start(start[2]), .mem_addr1(addr1[2]), .mem_addr2(addr2[2]), .mem_rd_en(rd_en[2]),
      .mem_rdata1(rdata1[2]), .mem_rdata2(rdata2[2]), .eval_chrom1(ec1[2]), .eval_chrom2(ec2[2]),
      .eval_fit1(ef1[2]), .eval_fit2(ef2[2]), .best_clear(clr[2]), .fitness1(f1[2]), .fitness2(f2[2]),
      .chrom1(c1[2]), .chrom2(c2[2]), .enable_second(en2[2]), .pair_valid(pv[2]), .busy(busy[2]), .done(done[2]));

   pop_pair_streamer #(.CHROM_WIDTH(8), .FIT_WIDTH(27), .POP_SIZE(1), .ADDR_WIDTH(4), .FIT_LATENCY(4)) u_dut3 (
      .clk(clk), .reset(reset), .start(start[3]), .mem_addr1(addr1[3]), .mem_addr2(addr2[3]), .mem_rd_en(rd_en[3]),
      .mem_rdata1(rdata1[3]), .mem_rdata2(rdata2[3]), .eval_chrom1(ec1[3]), .eval_chrom2(ec2[3]),
      .eval_fit1(ef1[3]), .eval_fit2(ef2[3]), .best_clear(clr[3]), .fitness1(f1[3]), .fitness2(f2[3]),
      .chrom1(c1[3]), .chrom2(c2[3]), .enable_second(en2[3]), .pair_valid(pv[3]), .busy(busy[3]), .done(done[3]));

   // Population memory: synchronous read, data one cycle after the strobe.
   always @(posedge clk) begin
      for (int d = 0; d < 4; d++) begin
         if (rd_en[d]) begin
            rdata1[d] <= mem[d][addr1[d]];
            rdata2[d] <= mem[d][addr2[d]];
         end
      end
   end

   // Evaluators: table lookup delayed by each instance's latency.
   always @(posedge clk) begin
      for (int d = 0; d < 4; d++) begin
         for (int s = 3; s > 0; s--) begin
            ev1[d][s] <= ev1[d][s-1];
            ev2[d][s] <= ev2[d][s-1];
         end
         ev1[d][0] <= fit_tab[ec1[d]];
         ev2[d][0] <= fit_tab[ec2[d]];
      end
   end

   always_comb begin
      for (int d = 0; d < 4; d++) begin
         ef1[d] = ev1[d][LATS[d]-1];
         ef2[d] = ev2[d][LATS[d]-1];
      end
   end

   // Best-fitness tracker, cleared by best_clear.
   always @(posedge clk) begin
      for (int d = 0; d < 4; d++) begin
         if (clr[d]) begin
            best[d] <= ALL1;
         end else if (pv[d]) begin
            cand = f1[d];
            if (en2[d] && f2[d] < cand) cand = f2[d];
            if (cand < best[d]) best[d] <= cand;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d cyc%0d: observed %0h expected %0h", tag, d, cur_n, obs, exp);
      end
   endtask

   function automatic logic [26:0] ref_min(input int d);
      logic [26:0] m;
      m = ALL1;
      for (int i = 0; i < POPS[d]; i++)
         if (fit_tab[mem[d][i]] < m) m = fit_tab[mem[d][i]];
      return m;
   endfunction

   task automatic randomize_tables();
      for (int c = 0; c < 256; c++) fit_tab[c] = 27'($urandom);
      for (int d = 0; d < 4; d++)
         for (int i = 0; i < 16; i++) mem[d][i] = 8'($urandom);
   endtask

   task automatic check_reset();
      for (int d = 0; d < 4; d++) begin
         chk("rst_pv", d, pv[d], 0);
         chk("rst_busy", d, busy[d], 0);
         chk("rst_done", d, done[d], 0);
         chk("rst_clear", d, clr[d], 0);
         chk("rst_rd_en", d, rd_en[d], 0);
         chk("rst_addr1", d, addr1[d], 0);
         chk("rst_addr2", d, addr2[d], 0);
         chk("rst_en2", d, en2[d], 0);
         chk("rst_chrom1", d, c1[d], 0);
         chk("rst_chrom2", d, c2[d], 0);
         chk("rst_fit1", d, f1[d], ALL1);
         chk("rst_fit2", d, f2[d], ALL1);
      end
   endtask

   // Cycle n counts from the start pulse (n=0): clear at 1, issue 2.., pairs at 4+L.., done after last pair.
   task automatic check_cycle(input int n);
      cur_n = n;
      for (int d = 0; d < 4; d++) begin : per_dut
         int p, np, fv, dn, k;
         logic sec;
         logic [7:0] ca, cb;
         p  = POPS[d];
         np = (p + 1) / 2;
         fv = 4 + LATS[d];
         dn = fv + np;
         chk("best_clear", d, clr[d], n == 1);
         chk("busy", d, busy[d], n >= 1 && n < dn);
         chk("done", d, done[d], n == dn);
         chk("rd_en", d, rd_en[d], n >= 2 && n < 2 + np);
         if (n >= 2 && n < 2 + np) begin
            k = n - 2;
            chk("addr1", d, addr1[d], 2 * k);
            chk("addr2", d, addr2[d], (2 * k + 1 < p) ? 2 * k + 1 : 0);
         end
         chk("pair_valid", d, pv[d], n >= fv && n < dn);
         if (n >= fv && n < dn) begin
            k   = n - fv;
            sec = (2 * k + 1 < p);
            ca  = mem[d][2 * k];
            cb  = sec ? mem[d][2 * k + 1] : 8'd0;
            chk("chrom1", d, c1[d], ca);
            chk("fitness1", d, f1[d], fit_tab[ca]);
            chk("enable_second", d, en2[d], sec);
            chk("chrom2", d, c2[d], cb);
            chk("fitness2", d, f2[d], sec ? fit_tab[cb] : ALL1);
         end else begin
            chk("bubble_fit1", d, f1[d], ALL1);
            chk("bubble_en2", d, en2[d], 0);
         end
         if (n == dn) chk("tracker_best", d, best[d], ref_min(d));
      end
   endtask

   task automatic run_scan(input bit busy_pulses);
      for (int d = 0; d < 4; d++) start[d] = 1'b1;
      tick();
      for (int d = 0; d < 4; d++) start[d] = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         check_cycle(n);
         if (busy_pulses) begin
            if (n == 1) for (int d = 0; d < 4; d++) start[d] = 1'b1;
            if (n == 7) begin
               start[0] = 1'b1;
               start[1] = 1'b1;
               start[3] = 1'b1;
            end
            if (n == 6) start[2] = 1'b1;
         end
         tick();
         for (int d = 0; d < 4; d++) start[d] = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1;
      for (int d = 0; d < 4; d++) start[d] = 1'b0;
      randomize_tables();
      tick();
      tick();
      cur_n = -1;
      check_reset();
      reset = 1'b0;
      tick();

      run_scan(1'b0);

      // Odd population with the minimum forced into slot 4.
      randomize_tables();
      for (int i = 0; i < 5; i++) mem[1][i] = 8'(37 * i + 5);
      fit_tab[mem[1][4]] = 27'd0;
      run_scan(1'b0);

      for (int i = 0; i < 20; i++) begin
         cur_n = 100 + i;
         for (int d = 0; d < 4; d++) begin
            chk("idle_pv", d, pv[d], 0);
            chk("idle_fit1", d, f1[d], ALL1);
            chk("idle_best", d, best[d], ref_min(d));
         end
         tick();
      end

      // start pulses in CLEAR, DRAIN and DONE must all be ignored.
      randomize_tables();
      run_scan(1'b1);

      // Reset in the third issue cycle aborts without a done pulse.
      for (int d = 0; d < 4; d++) start[d] = 1'b1;
      tick();
      for (int d = 0; d < 4; d++) start[d] = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      #1;
      cur_n = 200;
      check_reset();
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         cur_n = 210 + i;
         for (int d = 0; d < 4; d++) begin
            chk("abort_done", d, done[d], 0);
            chk("abort_busy", d, busy[d], 0);
            chk("abort_pv", d, pv[d], 0);
         end
      end

      randomize_tables();
      run_scan(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
